mbist_march_engine: RTL and testbench

Parametrised March-test engine for the MBIST datapath: on `start` it drives a single-port SRAM through MATS+ or March C- address/data sequences, compares read data against the expected background after a configurable read latency, counts faulty reads, captures the first failing address, and force-terminates once the allowable fault budget is exceeded. It replaces the fixed-width, per-algorithm decoder slices with one engine generalised in data width, address width, memory depth, read latency and algorithm selection.

---
 rtl/mbist_march_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_mbist_march_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_engine.sv
// mbist_march_engine
//   March-test engine for a single-port SRAM. On start it runs MATS+ or
//   March C- over addresses 0..MEM_DEPTH-1, one memory op per cycle, compares
//   read data RD_LATENCY cycles after each read, counts mismatches, records
//   the first failing address and aborts once the fault budget is exceeded.
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   start               : begin a test (only honoured in IDLE)
//   algo_sel            : 0 = MATS+, 1 = March C- (latched at start)
//   background          : data pattern "0"; pattern "1" is its inverse
//   allowable_faulty    : fault budget (latched at start)
//   error_exceed_ignore : 1 = never abort on budget (latched at start)
//   rdata               : memory read data
//   mem_en/write_read/address/wdata : memory command (held while mem_en = 0)
//   busy, done          : test in progress, one-cycle completion pulse
//   error, error_count, fail_addr, force_terminate : test result
module mbist_march_engine #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned MEM_DEPTH  = 2**ADDR_WIDTH,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  algo_sel,
   input  logic [DATA_WIDTH-1:0] background,
   input  logic [ADDR_WIDTH-1:0] allowable_faulty,
   input  logic                  error_exceed_ignore,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  mem_en,
   output logic                  write_read,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] error_count,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic                  force_terminate
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state_q, state_d;

   // Element direction: 1 = descending address order.
   function automatic logic elem_is_down(input logic algo, input logic [2:0] e);
      if (algo) return (e == 3'd3) || (e == 3'd4);
      else      return (e == 3'd2);
   endfunction

   // Element ops: {two_ops, first_is_write, first_value}; the second op of a
   // two-op element is always a write of the inverted first value.
   function automatic logic [2:0] elem_ops(input logic algo, input logic [2:0] e);
      logic [2:0] r;
      r = 3'b000;
      case (e)
         3'd0: r = 3'b010;
         3'd1: r = 3'b100;
         3'd2: r = 3'b101;
         3'd3: r = algo ? 3'b100 : 3'b000;
         3'd4: r = algo ? 3'b101 : 3'b000;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

   logic                  algo_q, ignore_q, last_q;
   logic [DATA_WIDTH-1:0] bg_q, exp_q;
   logic [ADDR_WIDTH-1:0] allow_q, addr_q, addr_n, cnt_inc;
   logic [2:0]            elem_q, elem_n, ops, drain_cnt;
   logic                  op_q, op_n;
   logic                  sel_algo, cur_down, op_we, op_one, elem_op_end, addr_end, is_final;
   logic [DATA_WIDTH-1:0] sel_bg, op_data;
   logic                  issue, mismatch, term, start_ok;

   logic [RD_LATENCY:1]                 pv;
   logic [RD_LATENCY:1][DATA_WIDTH-1:0] pexp;
   logic [RD_LATENCY:1][ADDR_WIDTH-1:0] paddr;

   // Op decode from the position counters. In IDLE the counters sit at op 0
   // and the unlatched inputs are used so op 0 can issue on the start edge.
   always_comb begin
      sel_algo    = (state_q == IDLE) ? algo_sel : algo_q;
      sel_bg      = (state_q == IDLE) ? background : bg_q;
      cur_down    = elem_is_down(sel_algo, elem_q);
      ops         = elem_ops(sel_algo, elem_q);
      op_we       = op_q ? 1'b1 : ops[1];
      op_one      = op_q ? ~ops[0] : ops[0];
      op_data     = op_one ? ~sel_bg : sel_bg;
      elem_op_end = ~ops[2] | op_q;
      addr_end    = cur_down ? (addr_q == '0) : (addr_q == LAST_ADDR);
      is_final    = elem_op_end && addr_end && (elem_q == (sel_algo ? 3'd5 : 3'd2));
      elem_n      = elem_q;
      addr_n      = addr_q;
      op_n        = op_q;
      if (!elem_op_end) begin
         op_n = 1'b1;
      end else begin
         op_n = 1'b0;
         if (addr_end) begin
            elem_n = elem_q + 3'd1;
            addr_n = elem_is_down(sel_algo, elem_n) ? LAST_ADDR : '0;
         end else begin
            addr_n = cur_down ? addr_q - 1'b1 : addr_q + 1'b1;
         end
      end
   end

   assign mismatch = pv[RD_LATENCY] && (rdata != pexp[RD_LATENCY]);
   assign cnt_inc  = (error_count == '1) ? error_count : error_count + 1'b1;
   assign term     = mismatch && (cnt_inc > allow_q) && !ignore_q;
   assign start_ok = (state_q == IDLE) && start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               issue   = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            // last_q marks that the op on the bus this cycle is the final one
            if (term || last_q) state_d = DRAIN;
            else                issue   = 1'b1;
         end
         DRAIN: begin
            busy = 1'b1;
            if (drain_cnt == 3'(RD_LATENCY - 1)) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Command registers, position counters, latched settings, compare pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_en     <= 1'b0;
         write_read <= 1'b0;
         address    <= '0;
         wdata      <= '0;
         exp_q      <= '0;
         elem_q     <= '0;
         addr_q     <= '0;
         op_q       <= 1'b0;
         last_q     <= 1'b0;
         algo_q     <= 1'b0;
         bg_q       <= '0;
         allow_q    <= '0;
         ignore_q   <= 1'b0;
         drain_cnt  <= '0;
         for (int unsigned i = 1; i <= RD_LATENCY; i++) begin
            pv[i]    <= 1'b0;
            pexp[i]  <= '0;
            paddr[i] <= '0;
         end
      end else begin
         mem_en <= issue;
         if (issue) begin
            write_read <= op_we;
            address    <= addr_q;
            exp_q      <= op_data;
            if (op_we) wdata <= op_data;
            elem_q     <= elem_n;
            addr_q     <= addr_n;
            op_q       <= op_n;
            last_q     <= is_final;
         end else if (state_q != RUN) begin
            elem_q <= '0;
            addr_q <= '0;
            op_q   <= 1'b0;
            last_q <= 1'b0;
         end
         if (start_ok) begin
            algo_q   <= algo_sel;
            bg_q     <= background;
            allow_q  <= allowable_faulty;
            ignore_q <= error_exceed_ignore;
         end
         drain_cnt <= (state_q == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
         pv[1]    <= mem_en & ~write_read;
         pexp[1]  <= exp_q;
         paddr[1] <= address;
         for (int unsigned i = 2; i <= RD_LATENCY; i++) begin
            pv[i]    <= pv[i-1];
            pexp[i]  <= pexp[i-1];
            paddr[i] <= paddr[i-1];
         end
      end
   end

   // Result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         error           <= 1'b0;
         error_count     <= '0;
         fail_addr       <= '0;
         force_terminate <= 1'b0;
      end else if (start_ok) begin
         error           <= 1'b0;
         error_count     <= '0;
         fail_addr       <= '0;
         force_terminate <= 1'b0;
      end else if (mismatch) begin
         error       <= 1'b1;
         error_count <= cnt_inc;
         if (!error) fail_addr <= paddr[RD_LATENCY];
         if (term) force_terminate <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mbist_march_engine.sv
// tb_mbist_march_engine
//   Two engines share one stimulus: P (16 words in a 5-bit address space,
//   read latency 3) and Q (single word, read latency 1). Each drives its own
//   behavioural SRAM with injectable stuck-at masks. At every start the bench
//   builds the expected op stream and result from its own March model and
//   pushes it to a queue; each issued op is popped and compared, and the
//   results are compared when done pulses.
module tb_mbist_march_engine;

   localparam int DW = 16;
   localparam int AW = 5;
   localparam int DP = 16;
   localparam int LP = 3;
   localparam int DQ = 1;
   localparam int LQ = 1;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } op_t;

   logic          clk, rst, start, algo, ign;
   logic [DW-1:0] bg;
   logic [AW-1:0] allow;

   logic          p_mem_en, p_wr, p_busy, p_done, p_error, p_ft;
   logic [AW-1:0] p_addr, p_ecnt, p_fail;
   logic [DW-1:0] p_wdata, p_rdata;
   logic          q_mem_en, q_wr, q_busy, q_done, q_error, q_ft;
   logic [AW-1:0] q_addr, q_ecnt, q_fail;
   logic [DW-1:0] q_wdata, q_rdata;

   logic [DW-1:0] mem_p [0:31];
   logic [DW-1:0] mem_q [0:31];
   logic [DW-1:0] rp [0:LP-1];
   logic [DW-1:0] rq [0:LQ-1];
   logic [DW-1:0] sa0 [0:31];
   logic [DW-1:0] sa1 [0:31];

   string mats [3] = '{"U w0", "U r0w1", "D r1w0"};
   string marc [6] = '{"U w0", "U r0w1", "U r1w0", "D r0w1", "D r1w0", "U r0"};

   op_t           opq_p [$];
   op_t           opq_q [$];
   int            exp_done [2];
   int            exp_left [2];
   logic [AW-1:0] exp_cnt  [2];
   logic [AW-1:0] exp_fail [2];
   logic          exp_term [2];
   bit            seen     [2];

   int n_checks = 0;
   int n_errors = 0;

   mbist_march_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DP), .RD_LATENCY(LP)) u_dut_p (
      .clk(clk), .rst(rst), .start(start), .algo_sel(algo), .background(bg),
      .allowable_faulty(allow), .error_exceed_ignore(ign), .rdata(p_rdata),
      .mem_en(p_mem_en), .write_read(p_wr), .address(p_addr), .wdata(p_wdata),
      .busy(p_busy), .done(p_done), .error(p_error), .error_count(p_ecnt),
      .fail_addr(p_fail), .force_terminate(p_ft));

   mbist_march_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DQ), .RD_LATENCY(LQ)) u_dut_q (
      .clk(clk), .rst(rst), .start(start), .algo_sel(algo), .background(bg),
      .allowable_faulty(allow), .error_exceed_ignore(ign), .rdata(q_rdata),
      .mem_en(q_mem_en), .write_read(q_wr), .address(q_addr), .wdata(q_wdata),
      .busy(q_busy), .done(q_done), .error(q_error), .error_count(q_ecnt),
      .fail_addr(q_fail), .force_terminate(q_ft));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SRAMs: stuck-at masks applied on the read path.
   always @(posedge clk) begin
      if (p_mem_en && p_wr) mem_p[p_addr] <= p_wdata;
      rp[0] <= (p_mem_en && !p_wr) ? ((mem_p[p_addr] | sa1[p_addr]) & ~sa0[p_addr]) : DW'($urandom);
      for (int i = 1; i < LP; i++) rp[i] <= rp[i-1];
      if (q_mem_en && q_wr) mem_q[q_addr] <= q_wdata;
      rq[0] <= (q_mem_en && !q_wr) ? ((mem_q[q_addr] | sa1[q_addr]) & ~sa0[q_addr]) : DW'($urandom);
      for (int i = 1; i < LQ; i++) rq[i] <= rq[i-1];
   end
   assign p_rdata = rp[LP-1];
   assign q_rdata = rq[LQ-1];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: expected op stream, mismatch count, first fail address,
   // abort point and done cycle for one engine of the given depth/latency.
   task automatic model(input int inst, input int depth, input int lat);
      op_t           ops [$];
      op_t           o;
      string         s;
      int            n, m, term_op;
      logic [AW-1:0] cnt, fail;
      logic [DW-1:0] got;
      bit            any;
      for (int e = 0; e < (algo ? 6 : 3); e++) begin
         s = algo ? marc[e] : mats[e];
         for (int i = 0; i < depth; i++) begin
            for (int j = 2; j + 1 < s.len(); j += 2) begin
               o.we = (s[j] == "w");
               o.a  = AW'((s[0] == "D") ? depth - 1 - i : i);
               o.d  = (s[j+1] == "1") ? ~bg : bg;
               ops.push_back(o);
            end
         end
      end
      n = ops.size(); m = n; term_op = -1;
      cnt = '0; fail = '0; any = 0;
      for (int k = 0; k < n; k++) begin
         if (term_op >= 0 && k > term_op + lat) begin
            m = k;
            break;
         end
         if (!ops[k].we) begin
            got = (ops[k].d | sa1[ops[k].a]) & ~sa0[ops[k].a];
            if (got != ops[k].d) begin
               if (!any) fail = ops[k].a;
               any = 1;
               if (cnt != '1) cnt = cnt + 1'b1;
               if (cnt > allow && !ign && term_op < 0) term_op = k;
            end
         end
      end
      exp_done[inst] = m + lat + 1;
      exp_left[inst] = n - m;
      exp_cnt[inst]  = cnt;
      exp_fail[inst] = fail;
      exp_term[inst] = (term_op >= 0);
      seen[inst]     = 0;
      if (inst == 0) opq_p = ops;
      else           opq_q = ops;
   endtask

   task automatic obs(input int inst, input int cyc, input logic men, input logic wr,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input logic bsy,
                      input logic dn, input logic er, input logic [AW-1:0] ec,
                      input logic [AW-1:0] fa, input logic ft);
      string pfx;
      op_t   e;
      bit    have;
      int    left;
      pfx = (inst == 0) ? "p" : "q";
      if (cyc == 1) check({pfx, "_busy_start"}, 64'(bsy), 64'(1));
      if (men) begin
         have = (inst == 0) ? (opq_p.size() != 0) : (opq_q.size() != 0);
         if (!have) begin
            check({pfx, "_extra_op"}, 64'(1), 64'(0));
         end else begin
            e = (inst == 0) ? opq_p.pop_front() : opq_q.pop_front();
            check($sformatf("%s_op_c%0d", pfx, cyc),
                  64'({wr, a, wr ? d : '0}), 64'({e.we, e.a, e.we ? e.d : '0}));
         end
      end
      if (dn && !seen[inst]) begin
         seen[inst] = 1;
         left = (inst == 0) ? opq_p.size() : opq_q.size();
         check({pfx, "_done_cycle"}, 64'(cyc), 64'(exp_done[inst]));
         check({pfx, "_busy_done"}, 64'(bsy), 64'(0));
         check({pfx, "_error"}, 64'(er), 64'(exp_cnt[inst] != '0));
         check({pfx, "_error_count"}, 64'(ec), 64'(exp_cnt[inst]));
         check({pfx, "_fail_addr"}, 64'(fa), 64'(exp_fail[inst]));
         check({pfx, "_force_term"}, 64'(ft), 64'(exp_term[inst]));
         check({pfx, "_ops_left"}, 64'(left), 64'(exp_left[inst]));
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_p"}, 64'({p_mem_en, p_wr, p_addr, p_wdata, p_busy, p_done, p_error, p_ecnt, p_fail, p_ft}), 64'(0));
      check({tag, "_q"}, 64'({q_mem_en, q_wr, q_addr, q_wdata, q_busy, q_done, q_error, q_ecnt, q_fail, q_ft}), 64'(0));
   endtask

   task automatic setup_test(input logic a, input logic [DW-1:0] b, input logic [AW-1:0] al, input logic ig);
      algo = a; bg = b; allow = al; ign = ig;
      for (int i = 0; i < 32; i++) begin
         sa0[i] = '0;
         sa1[i] = '0;
      end
   endtask

   // rst_at: cycle at which reset is asserted (0 = never); poke_at: cycle at
   // which a stray start is pulsed mid-run (0 = never).
   task automatic run(input int rst_at, input int poke_at);
      int cyc, dn_cnt;
      model(0, DP, LP);
      model(1, DQ, LQ);
      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      while (!(seen[0] && seen[1]) && cyc < 600) begin
         @(negedge clk);
         cyc++;
         start = (poke_at != 0 && cyc == poke_at);
         if (rst_at != 0 && cyc == rst_at) begin
            rst = 1'b1;
            #1;
            check_zero("rst_mid");
            dn_cnt = 0;
            repeat (5) begin
               @(negedge clk);
               dn_cnt += int'(p_done) + int'(q_done);
            end
            check("rst_no_done", 64'(dn_cnt), 64'(0));
            rst = 1'b0;
            opq_p.delete();
            opq_q.delete();
            repeat (2) @(negedge clk);
            return;
         end
         obs(0, cyc, p_mem_en, p_wr, p_addr, p_wdata, p_busy, p_done, p_error, p_ecnt, p_fail, p_ft);
         obs(1, cyc, q_mem_en, q_wr, q_addr, q_wdata, q_busy, q_done, q_error, q_ecnt, q_fail, q_ft);
      end
      start = 1'b0;
      check("run_completed", 64'({seen[0], seen[1]}), 64'(2'b11));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      setup_test(1'b0, '0, '0, 1'b0);
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // March C-, fault-free
      setup_test(1'b1, 16'h0000, 5'd0, 1'b0);
      run(0, 0);

      // MATS+, bit0 stuck-at-1 at address 3
      setup_test(1'b0, 16'hA5A5, 5'd4, 1'b0);
      sa1[3] = 16'h0001;
      run(0, 0);

      // March C-, whole word stuck-at-0 at 5 and 9, zero budget: abort
      setup_test(1'b1, 16'h0000, 5'd0, 1'b0);
      sa0[5] = 16'hFFFF; sa0[9] = 16'hFFFF;
      run(0, 0);

      // Same faults with the budget ignored, stray start mid-run
      setup_test(1'b1, 16'h0000, 5'd0, 1'b1);
      sa0[5] = 16'hFFFF; sa0[9] = 16'hFFFF;
      run(0, 8);

      // March C-, bit7 stuck-at-0 at address 0, budget 1: abort on 2nd fault
      setup_test(1'b1, 16'h3C5A, 5'd1, 1'b0);
      sa0[0] = 16'h0080;
      run(0, 0);

      // Reset in the middle of op 50, then a clean rerun
      setup_test(1'b1, 16'h0F0F, 5'd0, 1'b0);
      run(51, 0);
      setup_test(1'b1, 16'h0F0F, 5'd0, 1'b0);
      run(0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
